// File: rtl/execution_supervisor.sv
// execution_supervisor: cycle-counted run controller for a processor under test.
// The processor is held in reset for RESET_CYCLES cycles, then run until a halt line
// rises or the watchdog expires. The run is then extended by a drain period before
// the outcome is reported.
//
// Ports:
//   clk_i         processor clock, all state changes on the rising edge
//   rst_ni        asynchronous active-low reset
//   restart_i     synchronous restart request, sampled every cycle
//   halt_i        halt lines from processor/peripherals (rising edge in RUN ends the run)
//   cpu_rst_no    active-low reset to the processor
//   running_o     high while in RUN
//   done_o        high in DONE
//   timed_out_o   run ended by the watchdog (valid when done_o)
//   halt_src_o    lowest halt line index that ended the run
//   run_cycles_o  cycles spent in RUN, saturating
module execution_supervisor #(
  parameter int unsigned NUM_HALT         = 1,
  parameter int unsigned RESET_CYCLES     = 10,
  parameter int unsigned TIMEOUT_CYCLES   = 1250000,
  parameter int unsigned POST_HALT_CYCLES = 5,
  parameter int unsigned COUNT_WIDTH      = 32,
  localparam int unsigned SrcW            = (NUM_HALT > 1) ? $clog2(NUM_HALT) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   restart_i,
  input  logic [NUM_HALT-1:0]    halt_i,
  output logic                   cpu_rst_no,
  output logic                   running_o,
  output logic                   done_o,
  output logic                   timed_out_o,
  output logic [SrcW-1:0]        halt_src_o,
  output logic [COUNT_WIDTH-1:0] run_cycles_o
);

  // One counter serves both the reset hold and the drain period.
  localparam int unsigned CntMax = (RESET_CYCLES > POST_HALT_CYCLES) ? RESET_CYCLES
                                                                     : POST_HALT_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] HoldLast  = CntW'(RESET_CYCLES - 1);
  localparam logic [CntW-1:0] DrainLast =
    CntW'((POST_HALT_CYCLES == 0) ? 0 : POST_HALT_CYCLES - 1);
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [COUNT_WIDTH-1:0] TimeoutLast =
    COUNT_WIDTH'(TimeoutEn ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StHold, StRun, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [NUM_HALT-1:0]    halt_prev_q, halt_prev_d;
  logic [COUNT_WIDTH-1:0] run_cycles_q, run_cycles_d;
  logic                   timed_out_q, timed_out_d;
  logic [SrcW-1:0]        halt_src_q, halt_src_d;
  logic                   cpu_rst_n_q, cpu_rst_n_d;
  logic                   running_q, running_d;
  logic                   done_q, done_d;

  logic [NUM_HALT-1:0]    halt_edge;
  logic [SrcW-1:0]        first_idx;
  logic                   end_run;

  assign halt_edge = halt_i & ~halt_prev_q;

  // Lowest-index priority encoder over the halt edges.
  always_comb begin
    first_idx = '0;
    for (int i = int'(NUM_HALT) - 1; i >= 0; i--) begin
      if (halt_edge[i]) first_idx = SrcW'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    halt_prev_d  = halt_i;
    run_cycles_d = run_cycles_q;
    timed_out_d  = timed_out_q;
    halt_src_d   = halt_src_q;
    cpu_rst_n_d  = cpu_rst_n_q;
    running_d    = running_q;
    done_d       = done_q;
    end_run      = 1'b0;

    unique case (state_q)
      StHold: begin
        // A line held high through reset must fall and rise again to count.
        halt_prev_d = '1;
        if (cnt_q == HoldLast) begin
          state_d     = StRun;
          cnt_d       = '0;
          cpu_rst_n_d = 1'b1;
          running_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (run_cycles_q != '1) run_cycles_d = run_cycles_q + 1'b1;
        if (|halt_edge) begin
          end_run     = 1'b1;
          halt_src_d  = first_idx;
          timed_out_d = 1'b0;
        end else if (TimeoutEn && (run_cycles_q == TimeoutLast)) begin
          end_run     = 1'b1;
          timed_out_d = 1'b1;
        end
        if (end_run) begin
          running_d = 1'b0;
          cnt_d     = '0;
          if (POST_HALT_CYCLES == 0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (cnt_q == DrainLast) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        // Terminal; halt edges are ignored until restart.
      end
      default: state_d = StHold;
    endcase

    // Restart overrides everything, including a same-cycle halt or timeout.
    if (restart_i) begin
      state_d      = StHold;
      cnt_d        = '0;
      halt_prev_d  = '1;
      run_cycles_d = '0;
      timed_out_d  = 1'b0;
      halt_src_d   = '0;
      cpu_rst_n_d  = 1'b0;
      running_d    = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StHold;
      cnt_q        <= '0;
      halt_prev_q  <= '1;
      run_cycles_q <= '0;
      timed_out_q  <= 1'b0;
      halt_src_q   <= '0;
      cpu_rst_n_q  <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      halt_prev_q  <= halt_prev_d;
      run_cycles_q <= run_cycles_d;
      timed_out_q  <= timed_out_d;
      halt_src_q   <= halt_src_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      running_q    <= running_d;
      done_q       <= done_d;
    end
  end

  assign cpu_rst_no   = cpu_rst_n_q;
  assign running_o    = running_q;
  assign done_o       = done_q;
  assign timed_out_o  = timed_out_q;
  assign halt_src_o   = halt_src_q;
  assign run_cycles_o = run_cycles_q;

endmodule
